freq_counter_multi: RTL
=======================

// Module: freq_counter_multi
// PURPOSE
//  Parametrised multi-channel frequency counter; successor of the single-channel freq1 PIO counter.
//  Counts rising edges of NUM_CH asynchronous inputs over a common gate window of GATE_CYCLES clocks.
//  Latches per-channel results and serves them through a channel-select / readdata pair.
//  The readdata/select pair is exported via the freq_system Qsys conduit to the HPS.
// PARAMETERS
//  NUM_CH       8        number of measured input channels (1..16)
//  SEL_W        4        width of channel-select input; 2**SEL_W >= NUM_CH
//  CNT_W        24       edge-counter / result width (1..30)
//  GATE_CYCLES  50000000 gate window length in clk_clk cycles (>= 4); default = 1 s at 50 MHz
// PORTS
//  clk_clk        in   1       system clock
//  reset_reset_n  in   1       asynchronous active-low reset
//  freq_in        in   NUM_CH  asynchronous signals to measure
//  freq_sel       in   SEL_W   channel select (driven from HPS writedata)
//  freq_readdata  out  32      {valid, ovf, zero pad, count[CNT_W-1:0]} of selected channel
//  gate_done      out  1       one-cycle pulse when a gate window closes and results update
//  irq            out  1       [FREQ_COUNTER_IRQ_EN only] sticky interrupt
//  irq_ack        in   1       [FREQ_COUNTER_IRQ_EN only] clears irq
// BEHAVIOUR
//  Reset (async assert, sync deassert internally not required): all synchronisers, counters, results,
//   valid, ovf, gate counter cleared; freq_readdata=0, gate_done=0, irq=0.
//  Input path: per channel 2-FF synchroniser + 3rd FF; rising edge = sync & ~prev. Max measurable
//   rate clk_clk/2; edges arrive 3 cycles after the pin transition.
//  Gate counter: counts 0..GATE_CYCLES-1, wraps to 0. Terminal cycle = count==GATE_CYCLES-1.
//  Edge counters: +1 per detected edge; saturate at 2**CNT_W-1 and set per-channel ovf_run flag.
//  Terminal cycle: result[i] <= counter[i] + edge[i] (saturating); ovf[i] <= ovf_run[i] | sat;
//   counter[i] <= 0; ovf_run[i] <= 0; valid <= 1 (stays 1 until reset). Edge on terminal cycle
//   belongs to the closing window; no edge is lost or double-counted across windows.
//  gate_done asserts the cycle after the terminal cycle, with the new results visible.
//  Read path: freq_readdata registered, 1-cycle latency from freq_sel change or result update.
//   [31]=valid, [30]=ovf[sel], [29:CNT_W]=0, [CNT_W-1:0]=result[sel].
//   freq_sel >= NUM_CH -> freq_readdata = 0 (including valid bit).
//  Before first gate closes: valid=0, count=0.
//  Reset mid-window: partial counts discarded; next window starts fresh from gate count 0.
//  Static input (no edges): result 0, ovf 0.
// CONFIGURATION
//  FREQ_COUNTER_IRQ_EN defined: irq/irq_ack ports exist; irq sets on gate_done cycle, held until
//   irq_ack sampled high; if gate_done and irq_ack coincide, irq stays set (set wins).
//  Undefined: irq/irq_ack ports and logic absent; all other behaviour identical.
// TESTING
//  Reset: hold reset_reset_n=0 with toggling freq_in -> freq_readdata=0, gate_done=0 throughout.
//  NUM_CH=8,GATE_CYCLES=1000: ch0=clk/4, ch3=clk/10, sel=0 then 3 -> 0x800000FA then 0x80000064
//   after first gate_done; identical values on every subsequent window.
//  CNT_W=8,GATE_CYCLES=1000: ch1=clk/2 (500 edges) -> count 0xFF, bit30=1; next window with
//   ch1=clk/8 -> count 125 (0x7D), bit30=0.
//  freq_sel=9 with NUM_CH=8 -> freq_readdata=0 one cycle later; sel back to 0 -> valid data.
//  Assert reset at gate count 600, release, ch0=clk/4 -> first result 250, not 250+partial.
//  FREQ_COUNTER_IRQ_EN: irq rises with gate_done, holds until irq_ack; ack on gate_done cycle
//   -> irq remains 1.

Source files
------------

// File: rtl/freq_counter_multi_if.sv
// freq_counter_multi_if
//   Register-style read bus between the frequency counter and its host.
//   freq_sel      host -> counter  channel select
//   freq_readdata counter -> host  {valid, ovf, 0.., count} of selected channel
//   gate_done     counter -> host  one-cycle pulse per closed gate window
//   irq / irq_ack                  sticky interrupt and its clear; present only
//                                  when FREQ_COUNTER_IRQ_EN is defined
// Modports: master = host side, slave = counter side.
interface freq_counter_multi_if #(
  parameter int SEL_W = 4
);
  logic [SEL_W-1:0] freq_sel;
  logic [31:0]      freq_readdata;
  logic             gate_done;
`ifdef FREQ_COUNTER_IRQ_EN
  logic             irq;
  logic             irq_ack;

  modport master (output freq_sel, irq_ack, input freq_readdata, gate_done, irq);
  modport slave  (input freq_sel, irq_ack, output freq_readdata, gate_done, irq);
`else
  modport master (output freq_sel, input freq_readdata, gate_done);
  modport slave  (input freq_sel, output freq_readdata, gate_done);
`endif
endinterface

// File: rtl/freq_counter_multi.sv
// freq_counter_multi
//   Multi-channel frequency counter. Counts rising edges of NUM_CH asynchronous
//   inputs over a shared window of GATE_CYCLES clocks, latches per-channel
//   results at window close and serves them through a select/readdata pair.
// Ports:
//   clk_clk        system clock
//   reset_reset_n  asynchronous active-low reset
//   freq_in        NUM_CH asynchronous inputs to measure
//   bus            freq_counter_multi_if.slave (freq_sel, freq_readdata,
//                  gate_done, and irq/irq_ack when enabled)
// Optional feature: define FREQ_COUNTER_IRQ_EN for the sticky irq/irq_ack pair.
module freq_counter_multi #(
  parameter int NUM_CH      = 8,
  parameter int SEL_W       = 4,
  parameter int CNT_W       = 24,
  parameter int GATE_CYCLES = 50000000
) (
  input  logic                clk_clk,
  input  logic                reset_reset_n,
  input  logic [NUM_CH-1:0]   freq_in,
  freq_counter_multi_if.slave bus
);

  localparam int GATE_W = $clog2(GATE_CYCLES);

  logic [GATE_W-1:0]             r_gate;
  logic                          r_gate_done;
  logic                          r_valid;
  logic [31:0]                   r_rd;
  logic                          w_term;
  logic [NUM_CH-1:0][CNT_W-1:0]  w_result;
  logic [NUM_CH-1:0]             w_ovf;
  logic [31:0]                   w_rd_nxt;

  assign w_term = (r_gate == GATE_W'(GATE_CYCLES - 1));

  // Gate window: counts 0..GATE_CYCLES-1; valid latches once the first window closes.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_gate      <= '0;
      r_gate_done <= 1'b0;
      r_valid     <= 1'b0;
    end else begin
      r_gate      <= w_term ? '0 : r_gate + GATE_W'(1);
      r_gate_done <= w_term;
      if (w_term) r_valid <= 1'b1;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_lane
    // [0],[1] synchroniser, [2] previous value for edge detection
    logic [2:0]       r_sync;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_result;
    logic             r_ovf_run;
    logic             r_ovf;
    logic             w_edge;
    logic             w_full;
    logic             w_sat;
    logic [CNT_W-1:0] w_sum;

    assign w_edge = r_sync[1] & ~r_sync[2];
    assign w_full = &r_cnt;
    // an edge arriving while already at full scale is a lost edge
    assign w_sat  = w_edge & w_full;
    assign w_sum  = w_full ? r_cnt : r_cnt + CNT_W'(w_edge);

    // The terminal-cycle edge is folded into the closing result, and the
    // counter restarts from 0, so no edge straddles two windows.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
        r_sync    <= '0;
        r_cnt     <= '0;
        r_result  <= '0;
        r_ovf_run <= 1'b0;
        r_ovf     <= 1'b0;
      end else begin
        r_sync <= {r_sync[1:0], freq_in[g]};
        if (w_term) begin
          r_result  <= w_sum;
          r_ovf     <= r_ovf_run | w_sat;
          r_cnt     <= '0;
          r_ovf_run <= 1'b0;
        end else begin
          r_cnt <= w_sum;
          if (w_sat) r_ovf_run <= 1'b1;
        end
      end
    end

    assign w_result[g] = r_result;
    assign w_ovf[g]    = r_ovf;
  end

  // Select decode; an out-of-range select falls through to all-zero.
  always_comb begin
    w_rd_nxt = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (bus.freq_sel == SEL_W'(i)) begin
        w_rd_nxt     = 32'(w_result[i]);
        w_rd_nxt[31] = r_valid;
        w_rd_nxt[30] = w_ovf[i];
      end
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) r_rd <= '0;
    else                r_rd <= w_rd_nxt;
  end

  assign bus.freq_readdata = r_rd;
  assign bus.gate_done     = r_gate_done;

`ifdef FREQ_COUNTER_IRQ_EN
  logic r_irq;

  // Set on the terminal cycle so irq rises together with gate_done; also
  // forced during the gate_done cycle so a coincident ack cannot clear it.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n)              r_irq <= 1'b0;
    else if (w_term || r_gate_done)  r_irq <= 1'b1;
    else if (bus.irq_ack)            r_irq <= 1'b0;
  end

  assign bus.irq = r_irq;
`endif

endmodule
